// File: rtl/rasterizer_pkg.sv
// Shared types for the rasterizer backend: walker FSM states and the fragment record.
package rasterizer_pkg;

  localparam int RAST_DW = 12;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WALK  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } rast_state_e;

  typedef struct packed {
    logic [RAST_DW-1:0]        x;
    logic [RAST_DW-1:0]        y;
    logic signed [RAST_DW-1:0] z;
  } frag_t;

endpackage

// File: rtl/edge_stepper.sv
// Incremental evaluator for one planar function (edge or depth): row-start and
// current accumulators, stepped by +x or wrapped to the next row by +y.
module edge_stepper #(
  parameter int ACC_W   = 24,
  parameter int DELTA_W = 12
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic                      load_i,
  input  logic                      step_x_i,
  input  logic                      step_y_i,
  input  logic signed [ACC_W-1:0]   init_i,
  input  logic signed [DELTA_W-1:0] dx_i,
  input  logic signed [DELTA_W-1:0] dy_i,
  output logic signed [ACC_W-1:0]   val_o
);

  logic signed [ACC_W-1:0] row_q, row_d;
  logic signed [ACC_W-1:0] cur_q, cur_d;
  logic signed [ACC_W-1:0] dx_q, dx_d;
  logic signed [ACC_W-1:0] dy_q, dy_d;

  // Next-state: load captures start value and sign-extended deltas; a row wrap
  // re-seeds the current value from the advanced row start.
  always_comb begin
    row_d = row_q;
    cur_d = cur_q;
    dx_d  = dx_q;
    dy_d  = dy_q;
    if (load_i) begin
      row_d = init_i;
      cur_d = init_i;
      dx_d  = {{(ACC_W-DELTA_W){dx_i[DELTA_W-1]}}, dx_i};
      dy_d  = {{(ACC_W-DELTA_W){dy_i[DELTA_W-1]}}, dy_i};
    end else if (step_y_i) begin
      row_d = row_q + dy_q;
      cur_d = row_q + dy_q;
    end else if (step_x_i) begin
      cur_d = cur_q + dx_q;
    end else begin
      cur_d = cur_q;
    end
  end

  // Accumulator registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      row_q <= '0;
      cur_q <= '0;
      dx_q  <= '0;
      dy_q  <= '0;
    end else begin
      row_q <= row_d;
      cur_q <= cur_d;
      dx_q  <= dx_d;
      dy_q  <= dy_d;
    end
  end

  assign val_o = cur_q;

endmodule

// File: rtl/rasterizer_backend.sv
// Triangle scan converter: walks the bounding box row-major, one pixel per cycle,
// emitting covered fragments. Optional macro RASTER_EARLY_ROW_EXIT_EN ends a row early.
module rasterizer_backend
  import rasterizer_pkg::*;
#(
  parameter int DATAWIDTH     = RAST_DW,
  parameter int SCREEN_WIDTH  = 320,
  parameter int SCREEN_HEIGHT = 320
) (
  input  logic                          clk,
  input  logic                          rstn,
  output logic                          ready,
  input  logic                          i_dv,
  input  logic signed [DATAWIDTH-1:0]   bb_tl [2],
  input  logic signed [DATAWIDTH-1:0]   bb_br [2],
  input  logic signed [2*DATAWIDTH-1:0] edge_val0,
  input  logic signed [2*DATAWIDTH-1:0] edge_val1,
  input  logic signed [2*DATAWIDTH-1:0] edge_val2,
  input  logic signed [DATAWIDTH-1:0]   edge_delta0 [2],
  input  logic signed [DATAWIDTH-1:0]   edge_delta1 [2],
  input  logic signed [DATAWIDTH-1:0]   edge_delta2 [2],
  input  logic signed [DATAWIDTH-1:0]   z_coeff,
  input  logic signed [DATAWIDTH-1:0]   z_coeff_delta [2],
  output logic        [DATAWIDTH-1:0]   o_x,
  output logic        [DATAWIDTH-1:0]   o_y,
  output logic signed [DATAWIDTH-1:0]   o_z,
  output logic                          o_dv,
  input  logic                          i_frag_ready,
  output logic                          o_tri_done
);

  localparam int ACC_W = 2*DATAWIDTH;
  localparam logic signed [DATAWIDTH-1:0] X_LAST = DATAWIDTH'(SCREEN_WIDTH-1);
  localparam logic signed [DATAWIDTH-1:0] Y_LAST = DATAWIDTH'(SCREEN_HEIGHT-1);
  localparam logic signed [DATAWIDTH-1:0] ONE    = DATAWIDTH'(1);
  localparam logic signed [ACC_W-1:0] Z_HI = {{(DATAWIDTH+1){1'b0}}, {(DATAWIDTH-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] Z_LO = {{(DATAWIDTH+1){1'b1}}, {(DATAWIDTH-1){1'b0}}};

  function automatic logic signed [DATAWIDTH-1:0] sat_z(input logic signed [ACC_W-1:0] v);
    if (v > Z_HI)      return Z_HI[DATAWIDTH-1:0];
    else if (v < Z_LO) return Z_LO[DATAWIDTH-1:0];
    else               return v[DATAWIDTH-1:0];
  endfunction

  rast_state_e state_q, state_d;
  logic signed [DATAWIDTH-1:0] x_q, x_d, y_q, y_d;
  logic signed [DATAWIDTH-1:0] tl_x_q, tl_x_d, br_x_q, br_x_d, br_y_q, br_y_d;
  logic signed [DATAWIDTH-1:0] br_x_clip_s, br_y_clip_s;
  logic signed [ACC_W-1:0]     e0_s, e1_s, e2_s, z_s;
  logic        empty_s, advance_s, covered_s, row_end_s, last_s;
  logic        load_s, walk_go_s, out_load_s, step_x_s, step_y_s;
  logic        o_dv_q, o_dv_d, ready_q, done_q;
  frag_t       frag_q, frag_d;

  // The walk box is clipped to the screen so fragment coordinates stay on-screen.
  assign br_x_clip_s = (bb_br[0] > X_LAST) ? X_LAST : bb_br[0];
  assign br_y_clip_s = (bb_br[1] > Y_LAST) ? Y_LAST : bb_br[1];
  assign empty_s     = (br_x_clip_s < bb_tl[0]) || (br_y_clip_s < bb_tl[1]);
  assign advance_s   = !o_dv_q || i_frag_ready;
  assign covered_s   = !e0_s[ACC_W-1] && !e1_s[ACC_W-1] && !e2_s[ACC_W-1];

`ifdef RASTER_EARLY_ROW_EXIT_EN
  logic row_hit_q, row_hit_d;

  // Remembers coverage earlier in this row; a later miss means the span is over.
  always_comb begin
    row_hit_d = row_hit_q;
    if (load_s || step_y_s) row_hit_d = 1'b0;
    else if (walk_go_s)     row_hit_d = row_hit_q | covered_s;
    else                    row_hit_d = row_hit_q;
  end

  // Row-coverage flag register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) row_hit_q <= 1'b0;
    else       row_hit_q <= row_hit_d;
  end

  assign row_end_s = (x_q == br_x_q) || (row_hit_q && !covered_s);
`else
  assign row_end_s = (x_q == br_x_q);
`endif

  assign last_s = row_end_s && (y_q == br_y_q);

  // FSM state register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // FSM next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (i_dv) state_d = empty_s ? ST_DONE : ST_WALK;
                else      state_d = ST_IDLE;
      ST_WALK:  if (advance_s && last_s) state_d = ST_DRAIN;
                else                     state_d = ST_WALK;
      ST_DRAIN: if (advance_s) state_d = ST_DONE;
                else           state_d = ST_DRAIN;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // FSM outputs: capture and walk-advance strobes.
  always_comb begin
    load_s    = 1'b0;
    walk_go_s = 1'b0;
    case (state_q)
      ST_IDLE:  load_s    = i_dv;
      ST_WALK:  walk_go_s = advance_s;
      ST_DRAIN: walk_go_s = 1'b0;
      ST_DONE:  walk_go_s = 1'b0;
      default:  walk_go_s = 1'b0;
    endcase
  end

  assign out_load_s = walk_go_s && covered_s;
  assign step_x_s   = walk_go_s && !row_end_s;
  assign step_y_s   = walk_go_s && row_end_s && !last_s;

  // Walker position and captured box limits.
  always_comb begin
    x_d    = x_q;
    y_d    = y_q;
    tl_x_d = tl_x_q;
    br_x_d = br_x_q;
    br_y_d = br_y_q;
    if (load_s) begin
      x_d    = bb_tl[0];
      y_d    = bb_tl[1];
      tl_x_d = bb_tl[0];
      br_x_d = br_x_clip_s;
      br_y_d = br_y_clip_s;
    end else if (step_y_s) begin
      x_d = tl_x_q;
      y_d = y_q + ONE;
    end else if (step_x_s) begin
      x_d = x_q + ONE;
    end else begin
      x_d = x_q;
    end
  end

  // Output slot: loads on a covered pixel, empties on transfer, holds otherwise.
  always_comb begin
    o_dv_d = o_dv_q;
    frag_d = frag_q;
    if (out_load_s) begin
      o_dv_d   = 1'b1;
      frag_d.x = x_q;
      frag_d.y = y_q;
      frag_d.z = sat_z(z_s);
    end else if (i_frag_ready) begin
      o_dv_d = 1'b0;
    end else begin
      o_dv_d = o_dv_q;
    end
  end

  // Datapath and registered output flops.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      x_q     <= '0;
      y_q     <= '0;
      tl_x_q  <= '0;
      br_x_q  <= '0;
      br_y_q  <= '0;
      o_dv_q  <= 1'b0;
      frag_q  <= '0;
      ready_q <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      x_q     <= x_d;
      y_q     <= y_d;
      tl_x_q  <= tl_x_d;
      br_x_q  <= br_x_d;
      br_y_q  <= br_y_d;
      o_dv_q  <= o_dv_d;
      frag_q  <= frag_d;
      ready_q <= (state_d == ST_IDLE);
      done_q  <= (state_d == ST_DONE);
    end
  end

  edge_stepper #(.ACC_W(ACC_W), .DELTA_W(DATAWIDTH)) u_e0 (
    .clk(clk), .rstn(rstn), .load_i(load_s), .step_x_i(step_x_s), .step_y_i(step_y_s),
    .init_i(edge_val0), .dx_i(edge_delta0[0]), .dy_i(edge_delta0[1]), .val_o(e0_s));
  edge_stepper #(.ACC_W(ACC_W), .DELTA_W(DATAWIDTH)) u_e1 (
    .clk(clk), .rstn(rstn), .load_i(load_s), .step_x_i(step_x_s), .step_y_i(step_y_s),
    .init_i(edge_val1), .dx_i(edge_delta1[0]), .dy_i(edge_delta1[1]), .val_o(e1_s));
  edge_stepper #(.ACC_W(ACC_W), .DELTA_W(DATAWIDTH)) u_e2 (
    .clk(clk), .rstn(rstn), .load_i(load_s), .step_x_i(step_x_s), .step_y_i(step_y_s),
    .init_i(edge_val2), .dx_i(edge_delta2[0]), .dy_i(edge_delta2[1]), .val_o(e2_s));
  edge_stepper #(.ACC_W(ACC_W), .DELTA_W(DATAWIDTH)) u_z (
    .clk(clk), .rstn(rstn), .load_i(load_s), .step_x_i(step_x_s), .step_y_i(step_y_s),
    .init_i({{DATAWIDTH{z_coeff[DATAWIDTH-1]}}, z_coeff}),
    .dx_i(z_coeff_delta[0]), .dy_i(z_coeff_delta[1]), .val_o(z_s));

  assign ready      = ready_q;
  assign o_dv       = o_dv_q;
  assign o_x        = frag_q.x;
  assign o_y        = frag_q.y;
  assign o_z        = frag_q.z;
  assign o_tri_done = done_q;

endmodule

// File: tb/tb_rasterizer_backend.sv
// Directed bench for rasterizer_backend: a direct-formula reference model fills a
// fragment scoreboard; a monitor pops and compares on every accepted fragment.
module tb_rasterizer_backend;

  typedef struct {
    int x;
    int y;
    int z;
  } exp_frag_t;

  logic               clk = 1'b0;
  logic               rstn = 1'b0;
  logic               ready;
  logic               i_dv = 1'b0;
  logic signed [11:0] bb_tl [2];
  logic signed [11:0] bb_br [2];
  logic signed [23:0] edge_val0, edge_val1, edge_val2;
  logic signed [11:0] edge_delta0 [2];
  logic signed [11:0] edge_delta1 [2];
  logic signed [11:0] edge_delta2 [2];
  logic signed [11:0] z_coeff;
  logic signed [11:0] z_coeff_delta [2];
  logic        [11:0] o_x, o_y;
  logic signed [11:0] o_z;
  logic               o_dv;
  logic               i_frag_ready = 1'b1;
  logic               o_tri_done;

  exp_frag_t sb[$];
  int n_asserts = 0;
  int n_fail    = 0;

  rasterizer_backend dut (
    .clk(clk), .rstn(rstn), .ready(ready), .i_dv(i_dv),
    .bb_tl(bb_tl), .bb_br(bb_br),
    .edge_val0(edge_val0), .edge_val1(edge_val1), .edge_val2(edge_val2),
    .edge_delta0(edge_delta0), .edge_delta1(edge_delta1), .edge_delta2(edge_delta2),
    .z_coeff(z_coeff), .z_coeff_delta(z_coeff_delta),
    .o_x(o_x), .o_y(o_y), .o_z(o_z), .o_dv(o_dv),
    .i_frag_ready(i_frag_ready), .o_tri_done(o_tri_done));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp_v);
    n_asserts++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  // Reference: evaluate every box pixel directly from the plane equations.
  task automatic push_model();
    int e0, e1, e2, z, dx, dy;
    for (int yy = int'(bb_tl[1]); yy <= int'(bb_br[1]); yy++) begin
      for (int xx = int'(bb_tl[0]); xx <= int'(bb_br[0]); xx++) begin
        dx = xx - int'(bb_tl[0]);
        dy = yy - int'(bb_tl[1]);
        e0 = int'(edge_val0) + int'(edge_delta0[0])*dx + int'(edge_delta0[1])*dy;
        e1 = int'(edge_val1) + int'(edge_delta1[0])*dx + int'(edge_delta1[1])*dy;
        e2 = int'(edge_val2) + int'(edge_delta2[0])*dx + int'(edge_delta2[1])*dy;
        z  = int'(z_coeff) + int'(z_coeff_delta[0])*dx + int'(z_coeff_delta[1])*dy;
        if (z > 2047)  z = 2047;
        if (z < -2048) z = -2048;
        if (e0 >= 0 && e1 >= 0 && e2 >= 0) sb.push_back('{xx, yy, z});
      end
    end
  endtask

  task automatic set_tri(input int tx, input int ty, input int bx, input int by,
                         input int ev0, input int d0x, input int z0, input int dzx, input int dzy);
    bb_tl[0] = 12'(tx); bb_tl[1] = 12'(ty);
    bb_br[0] = 12'(bx); bb_br[1] = 12'(by);
    edge_val0 = 24'(ev0); edge_val1 = 24'sd0; edge_val2 = 24'sd0;
    edge_delta0[0] = 12'(d0x); edge_delta0[1] = 12'sd0;
    edge_delta1[0] = 12'sd0;   edge_delta1[1] = 12'sd0;
    edge_delta2[0] = 12'sd0;   edge_delta2[1] = 12'sd0;
    z_coeff = 12'(z0);
    z_coeff_delta[0] = 12'(dzx); z_coeff_delta[1] = 12'(dzy);
  endtask

  task automatic capture();
    int k;
    k = 0;
    @(posedge clk); #1;
    while (!ready && k < 50) begin
      @(posedge clk); #1;
      k++;
    end
    chk("ready_before_capture", ready, 1);
    i_dv = 1'b1;
    @(posedge clk); #1;
    i_dv = 1'b0;
  endtask

  // Counts cycles from the capture edge to o_tri_done, then checks it is a single pulse.
  task automatic wait_done(input string tag, input int exp_cycles);
    int cyc;
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!o_tri_done && cyc < 300);
    if (exp_cycles >= 0) chk(tag, cyc, exp_cycles);
    else                 chk(tag, o_tri_done, 1);
    @(negedge clk);
    chk("tri_done_pulse", o_tri_done, 0);
    chk("ready_after_done", ready, 1);
    chk("scoreboard_drained", sb.size(), 0);
  endtask

  // Monitor: every accepted fragment must match the head of the scoreboard.
  always @(negedge clk) begin
    if (o_dv && i_frag_ready) begin
      if (sb.size() == 0) begin
        chk("unexpected_frag_count", 1, 0);
      end else begin
        exp_frag_t f;
        f = sb.pop_front();
        chk("frag_x", o_x, f.x);
        chk("frag_y", o_y, f.y);
        chk("frag_z", o_z, f.z);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, asserts %0d", n_asserts);
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    logic [11:0] sx, sy;
    logic signed [11:0] sz;
    set_tri(0, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (3) @(posedge clk);
    #1 rstn = 1'b1;
    @(negedge clk);
    chk("reset_ready", ready, 1);
    chk("reset_o_dv", o_dv, 0);
    chk("reset_done", o_tri_done, 0);
    chk("reset_o_x", o_x, 0);
    chk("reset_o_z", o_z, 0);

    // Single row, all covered, z ramps by 2.
    set_tri(2, 3, 4, 3, 0, 0, 10, 2, 0);
    push_model();
    capture();
    wait_done("t1_walk_cycles", 5);

    // Left pixel outside edge 0.
    set_tri(2, 3, 4, 3, -1, 1, 10, 2, 0);
    push_model();
    capture();
    wait_done("t2_walk_cycles", 5);

    // Backpressure: first fragment must hold while the consumer stalls.
    set_tri(0, 0, 1, 1, 0, 0, 5, 1, 2);
    push_model();
    @(posedge clk); #1 i_frag_ready = 1'b0;
    capture();
    k = 0;
    while (!o_dv && k < 20) begin
      @(negedge clk);
      k++;
    end
    chk("stall_first_valid", o_dv, 1);
    sx = o_x; sy = o_y; sz = o_z;
    chk("stall_first_x", sx, 0);
    chk("stall_first_z", sz, 5);
    repeat (3) begin
      @(negedge clk);
      chk("stall_hold_dv", o_dv, 1);
      chk("stall_hold_x", o_x, sx);
      chk("stall_hold_y", o_y, sy);
      chk("stall_hold_z", o_z, sz);
    end
    @(posedge clk); #1 i_frag_ready = 1'b1;
    wait_done("t3_done", -1);

    // Narrow span in a wide box: early row exit shortens the walk.
    set_tri(0, 0, 7, 1, 1, -1, 0, 0, 0);
    push_model();
    capture();
`ifdef RASTER_EARLY_ROW_EXIT_EN
    wait_done("t4_walk_cycles", 8);
`else
    wait_done("t4_walk_cycles", 18);
`endif

    // Empty box: no fragments, done right after capture.
    set_tri(5, 5, 4, 5, 0, 0, 0, 0, 0);
    push_model();
    capture();
    wait_done("t5_empty_cycles", 1);

    // Depth saturates at the positive limit.
    set_tri(0, 0, 3, 0, 0, 0, 2000, 30, 0);
    push_model();
    capture();
    wait_done("t6_sat_cycles", 6);

    // Reset in the middle of a large walk.
    set_tri(0, 0, 9, 9, 0, 0, 100, 1, 1);
    push_model();
    capture();
    repeat (5) @(negedge clk);
    @(posedge clk); #1 rstn = 1'b0;
    #1;
    chk("midreset_o_dv", o_dv, 0);
    chk("midreset_ready", ready, 1);
    chk("midreset_o_x", o_x, 0);
    sb.delete();
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;
    @(negedge clk);
    chk("postreset_ready", ready, 1);
    chk("postreset_o_dv", o_dv, 0);

    set_tri(2, 3, 4, 3, 0, 0, 10, 2, 0);
    push_model();
    capture();
    wait_done("t7_after_reset", 5);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
